prg_loader: RTL and testbench
=============================

PRG_LOADER -- requirements
Module: prg_loader

Interface
REQ-001 Parameter PRG_INDEX, default 8'h41: the ioctl_index value that selects a PRG download.
REQ-002 Parameter PTR_BASE, default 16'h002A: address of the first BASIC end-of-program pointer byte.
REQ-003 Parameter RAM_TOP, default 16'h8000: first address that is not user RAM. Data writes are allowed only below this address.
REQ-004 clk  in  1  system clock. All logic is synchronous to its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ioctl_download  in  1  download window is active.
REQ-007 ioctl_index  in  8  index of the file being downloaded.
REQ-008 ioctl_wr  in  1  one-cycle strobe: a byte is valid this cycle.
REQ-009 ioctl_addr  in  25  byte offset within the file.
REQ-010 ioctl_dout  in  8  file byte.
REQ-011 ioctl_wait  out  1  backpressure to the HPS. No new ioctl_wr arrives while this is high.
REQ-012 dma_req  out  1  a write request to CPU RAM is pending.
REQ-013 dma_ack  in  1  one-cycle acknowledge: the RAM has accepted the current write.
REQ-014 dma_addr  out  16  write address.
REQ-015 dma_din  out  8  write data.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse when the pointer fix-up has completed.
REQ-018 overflow  out  1  sticky flag: at least one data byte was dropped at or above RAM_TOP.
REQ-019 end_addr  out  16  address one past the last byte written.

Function
REQ-020 The block is active only for downloads where ioctl_index==PRG_INDEX. All other indices are ignored and cause no output activity.
REQ-021 States: IDLE, HEADER, DATA, WRITE, PTR, DONE.
REQ-022 IDLE -> HEADER when ioctl_download rises with a matching index. On this transition the load address, overflow and the pointer counter are cleared.
REQ-023 HEADER: the byte at ioctl_addr 0 sets load_addr[7:0] and the byte at ioctl_addr 1 sets load_addr[15:8]. After the second byte the state moves to DATA and the write address is set to load_addr.
REQ-024 DATA: on ioctl_wr with write address < RAM_TOP, in the same cycle:
  - latch dma_addr and dma_din;
  - assert dma_req and ioctl_wait;
  - go to WRITE.
REQ-025 DATA: on ioctl_wr with write address >= RAM_TOP, drop the byte, set overflow, and leave the write address unchanged. No DMA request is issued.
REQ-026 WRITE: hold dma_req, dma_addr and dma_din stable until dma_ack. On dma_ack:
  - deassert dma_req and ioctl_wait in the next cycle;
  - increment the write address, wrapping modulo 2^16;
  - return to DATA.
REQ-027 ioctl_wait is high exactly while the state is WRITE or PTR. A write therefore costs at least two cycles.
REQ-028 When ioctl_download falls in DATA, go to PTR. If it falls in WRITE, finish the pending write first, then go to PTR.
REQ-029 When ioctl_download falls in HEADER, go to IDLE with no writes and no done pulse.
REQ-030 end_addr equals the write address at the moment PTR is entered.
REQ-031 PTR issues six sequential DMA writes to PTR_BASE+0 .. PTR_BASE+5 with data end_lo, end_hi, end_lo, end_hi, end_lo, end_hi. This sets VARTAB, ARYTAB and STREND.
REQ-032 In PTR each write uses the same req/ack handshake as WRITE. After the sixth ack, go to DONE.
REQ-033 DONE pulses done for one cycle, then goes to IDLE. overflow and end_addr hold their values until the next PRG download starts.
REQ-034 A rising edge of ioctl_download with a matching index, in any non-IDLE state, aborts the current sequence:
  - dma_req drops immediately;
  - no pointer writes are made;
  - the block restarts in HEADER.
REQ-035 If ioctl_wr and the fall of ioctl_download occur in the same cycle, the byte is processed first.

Reset
REQ-036 reset_n low asynchronously forces:
  - state IDLE;
  - dma_req, ioctl_wait, busy, done, overflow = 0;
  - dma_addr, dma_din, end_addr = 0.
REQ-037 A reset during WRITE or PTR abandons the transfer with no further DMA activity. The first clock edge after reset release has no side effects.

Structure
REQ-038 A shared package pet_pkg holds:
  - the state enumeration type;
  - constants PRG_INDEX_DEF, VARTAB_ADDR (16'h002A) and RAM_TOP_DEF (16'h8000).
REQ-039 One sub-module, dma_write_port, owns the req/ack handshake and the address/data hold registers. prg_loader instantiates it once and uses it for both data writes and pointer writes.

Verification
REQ-040 Load a PRG with header 01 04 followed by bytes AA BB CC, with dma_ack returned one cycle after each req. Required:
  - RAM writes 0401=AA, 0402=BB, 0403=CC;
  - then 002A=04, 002B=04, 002C=04, 002D=04, 002E=04, 002F=04;
  - done pulses once, end_addr=0404, overflow=0.
REQ-041 Header FE 7F followed by 4 bytes. Required: writes to 7FFE and 7FFF only; overflow=1; end_addr=8000; pointer bytes 00,80 repeated three times.
REQ-042 Hold dma_ack low for 10 cycles on the second data byte. Required: ioctl_wait stays high, and dma_addr and dma_din stay stable throughout; no byte is lost.
REQ-043 Download with ioctl_index=00. Required: dma_req is never asserted, ioctl_wait stays 0, done never pulses.
REQ-044 Drop ioctl_download after only 1 header byte. Required: return to IDLE, no DMA writes, no done pulse.
REQ-045 Assert reset_n low mid-PTR after 3 pointer writes. Required: dma_req=0 immediately; no further writes after reset release; busy=0.

Source files
------------

// File: rtl/pet_pkg.sv
// Shared types and constants for the PRG loader block.
package pet_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_PTR    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // ioctl_index that identifies a PRG file
  localparam logic [7:0]  PRG_INDEX_DEF = 8'h41;
  // First of the BASIC end-of-program pointers (VARTAB, ARYTAB, STREND)
  localparam logic [15:0] VARTAB_ADDR   = 16'h002A;
  // First address above user RAM
  localparam logic [15:0] RAM_TOP_DEF   = 16'h8000;
  // Three 16-bit pointers, written low byte first
  localparam int          PTR_WRITES    = 6;

endpackage

// File: rtl/dma_write_port.sv
// Single-entry write port toward CPU RAM: holds address/data and runs the
// req/ack handshake. Used for both file data and pointer fix-up writes.
module dma_write_port (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        dma_ack,
  output logic        dma_req,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        accepted
);

  // The RAM takes the write in the cycle it acknowledges a pending request
  assign accepted = dma_req & dma_ack;

  // Request flag and hold registers; abort beats a new start, start beats ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_req  <= 1'b0;
      dma_addr <= '0;
      dma_din  <= '0;
    end else if (abort) begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, so the order of these branches cannot create races.
      dma_req <= 1'b0;
    end else if (start) begin
      dma_req  <= 1'b1;
      dma_addr <= addr;
      dma_din  <= data;
    end else if (accepted) begin
      dma_req <= 1'b0;
    end
  end

endmodule

// File: rtl/prg_loader.sv
// Streams a Commodore PRG file from the HPS ioctl bus into CPU RAM, then
// rewrites the BASIC end-of-program pointers to the address after the load.
module prg_loader
  import pet_pkg::*;
#(
  parameter logic [7:0]  PRG_INDEX = PRG_INDEX_DEF,
  parameter logic [15:0] PTR_BASE  = VARTAB_ADDR,
  parameter logic [15:0] RAM_TOP   = RAM_TOP_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        dma_req,
  input  logic        dma_ack,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] end_addr
);

  state_t      state, state_nxt;
  logic        dl_prev;
  logic [15:0] load_addr;
  logic [15:0] wr_addr;
  logic [2:0]  ptr_cnt;

  logic        dl_rise;
  logic        wr_ok;
  logic        accepted;
  logic        restart, hdr_lo, hdr_hi, data_start, drop;
  logic        wr_inc, ptr_enter, ptr_start, ptr_inc;
  logic        wp_start;
  logic [15:0] wp_addr;
  logic [7:0]  wp_data;

  // A new PRG download begins on the rising edge of the window with our index
  assign dl_rise = ioctl_download & ~dl_prev & (ioctl_index == PRG_INDEX);
  assign wr_ok   = (wr_addr < RAM_TOP);

  // Data bytes and pointer bytes share the one write port
  assign wp_start = data_start | ptr_start;
  assign wp_addr  = data_start ? wr_addr : PTR_BASE + 16'(ptr_cnt);
  assign wp_data  = data_start ? ioctl_dout
                               : (ptr_cnt[0] ? end_addr[15:8] : end_addr[7:0]);

  dma_write_port u_port (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (wp_start),
    .abort    (restart),
    .addr     (wp_addr),
    .data     (wp_data),
    .dma_ack  (dma_ack),
    .dma_req  (dma_req),
    .dma_addr (dma_addr),
    .dma_din  (dma_din),
    .accepted (accepted)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and per-cycle datapath strobes; a restart overrides everything
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    restart    = 1'b0;
    hdr_lo     = 1'b0;
    hdr_hi     = 1'b0;
    data_start = 1'b0;
    drop       = 1'b0;
    wr_inc     = 1'b0;
    ptr_enter  = 1'b0;
    ptr_start  = 1'b0;
    ptr_inc    = 1'b0;
    if (dl_rise) begin
      restart   = 1'b1;
      state_nxt = ST_HEADER;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_HEADER: begin
          hdr_lo = ioctl_wr && (ioctl_addr == 25'd0);
          if (ioctl_wr && (ioctl_addr == 25'd1)) begin
            hdr_hi    = 1'b1;
            state_nxt = ST_DATA;
          end else if (!ioctl_download) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          // A byte arriving with the end of the window is handled first
          if (ioctl_wr && wr_ok) begin
            data_start = 1'b1;
            state_nxt  = ST_WRITE;
          end else begin
            drop = ioctl_wr;
            if (!ioctl_download) begin
              ptr_enter = 1'b1;
              state_nxt = ST_PTR;
            end
          end
        end
        ST_WRITE: begin
          if (accepted) begin
            wr_inc = 1'b1;
            if (!ioctl_download) begin
              ptr_enter = 1'b1;
              state_nxt = ST_PTR;
            end else begin
              state_nxt = ST_DATA;
            end
          end
        end
        ST_PTR: begin
          // ptr_cnt counts completed pointer writes; the next one is issued
          // in the idle cycle after each acknowledge
          if (accepted) begin
            if (ptr_cnt == 3'(PTR_WRITES - 1)) state_nxt = ST_DONE;
            else                               ptr_inc   = 1'b1;
          end else if (!dma_req) begin
            ptr_start = 1'b1;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Load address, write pointer, pointer counter and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Treat the window as already high so a download still in progress
      // at reset release is not mistaken for a fresh start.
      dl_prev   <= 1'b1;
      load_addr <= '0;
      wr_addr   <= '0;
      ptr_cnt   <= '0;
      overflow  <= 1'b0;
      end_addr  <= '0;
    end else begin
      dl_prev <= ioctl_download;
      if (restart) begin
        load_addr <= '0;
        overflow  <= 1'b0;
        ptr_cnt   <= '0;
      end else begin
        if (hdr_lo) load_addr[7:0] <= ioctl_dout;
        if (hdr_hi) begin
          load_addr[15:8] <= ioctl_dout;
          wr_addr         <= {ioctl_dout, load_addr[7:0]};
        end
        if (drop)      overflow <= 1'b1;
        if (wr_inc)    wr_addr  <= wr_addr + 16'd1;
        if (ptr_enter) end_addr <= wr_inc ? wr_addr + 16'd1 : wr_addr;
        if (ptr_inc)   ptr_cnt  <= ptr_cnt + 3'd1;
      end
    end
  end

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign ioctl_wait = (state == ST_WRITE) || (state == ST_PTR);

endmodule

// File: tb/tb_prg_loader.sv
// Self-checking bench for prg_loader: directed scenarios plus randomized PRG
// loads compared against a behavioural model of the expected RAM writes.
module tb_prg_loader;

  localparam logic [7:0]  PRG_IDX = 8'h41;
  localparam logic [15:0] PTR_AT  = 16'h002A;
  localparam int          TOP     = 32'h8000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        dma_req;
  logic        dma_ack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] end_addr;

  always #5 clk = ~clk;

  prg_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dma_req        (dma_req),
    .dma_ack        (dma_ack),
    .dma_addr       (dma_addr),
    .dma_din        (dma_din),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .end_addr       (end_addr)
  );

  int          checks = 0;
  int          errors = 0;
  logic [23:0] wq[$];
  logic [23:0] exp_q[$];
  logic [7:0]  payload[$];
  logic        exp_ovf;
  logic [15:0] exp_end;
  int          ack_delay   = 0;
  int          stall_index = -1;
  int          stall_len   = 0;
  int          ack_count   = 0;
  int          req_seen    = 0;
  int          wait_seen   = 0;
  int          busy_seen   = 0;
  int          done_cnt    = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // RAM model: acknowledges each request after a programmable number of
  // cycles, logs accepted writes and checks the request is held stable
  initial begin : responder
    int          held;
    int          lim;
    logic [15:0] a0;
    logic [7:0]  d0;
    held = 0; lim = 0; a0 = '0; d0 = '0;
    dma_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (dma_ack) begin
        dma_ack = 1'b0;
        held    = 0;
      end else if (dma_req) begin
        if (held == 0) begin
          a0  = dma_addr;
          d0  = dma_din;
          lim = (ack_count == stall_index) ? stall_len : ack_delay;
        end else begin
          check("hold_addr", 32'(dma_addr), 32'(a0));
          check("hold_din", 32'(dma_din), 32'(d0));
          check("hold_wait", 32'(ioctl_wait), 32'd1);
        end
        if (held >= lim) begin
          dma_ack = 1'b1;
          wq.push_back({dma_addr, dma_din});
          ack_count++;
        end
        held++;
      end else begin
        held = 0;
      end
    end
  end

  // Activity monitor
  initial forever begin
    @(posedge clk); #1;
    if (dma_req)    req_seen++;
    if (ioctl_wait) wait_seen++;
    if (busy)       busy_seen++;
    if (done)       done_cnt++;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    wq.delete();
    ack_count = 0;
    req_seen  = 0;
    wait_seen = 0;
    busy_seen = 0;
    done_cnt  = 0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit fall);
    int n = 0;
    while (ioctl_wait && n < 300) begin tick(); n++; end
    check("wait_bound", 32'(ioctl_wait), 32'd0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (fall) ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    check("idle_bound", 32'(busy), 32'd0);
  endtask

  // Expected RAM traffic: bytes land from the load address upward while below
  // the top of RAM, the rest are dropped; then three copies of the end address
  task automatic build_model(input logic [15:0] load);
    int a = int'(load);
    exp_q.delete();
    exp_ovf = 1'b0;
    foreach (payload[i]) begin
      if (a < TOP) begin
        exp_q.push_back({a[15:0], payload[i]});
        a = a + 1;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    exp_end = a[15:0];
    for (int k = 0; k < 6; k++)
      exp_q.push_back({PTR_AT + 16'(k), (k % 2 == 0) ? exp_end[7:0] : exp_end[15:8]});
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_nwr"}, 32'(wq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(wq[i]), 32'(exp_q[i]));
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_end"}, 32'(end_addr), 32'(exp_end));
  endtask

  task automatic run_prg(input string tag, input logic [15:0] load,
                         input int delay, input bit fall_on_last);
    ack_delay = delay;
    clear_log();
    build_model(load);
    start_dl(PRG_IDX);
    send_byte(25'd0, load[7:0], 1'b0);
    send_byte(25'd1, load[15:8], 1'b0);
    foreach (payload[i])
      send_byte(25'(i + 2), payload[i], fall_on_last && (i == payload.size() - 1));
    ioctl_download = 1'b0;
    wait_idle(3000);
    tick();
    compare_log(tag);
  endtask

  initial begin : main
    int          n;
    logic [15:0] load;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = '0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(dma_req), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_addr", 32'(dma_addr), 32'd0);
    check("rst_din", 32'(dma_din), 32'd0);
    check("rst_end", 32'(end_addr), 32'd0);
    reset_n = 1'b1;
    tick(); tick();
    check("rel_busy", 32'(busy), 32'd0);

    // Basic load: 01 04 AA BB CC
    payload = '{8'hAA, 8'hBB, 8'hCC};
    run_prg("basic", 16'h0401, 0, 1'b0);
    check("basic_end_abs", 32'(end_addr), 32'h0404);

    // Load crossing the top of RAM
    payload = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_prg("top", 16'h7FFE, 0, 1'b0);
    check("top_end_abs", 32'(end_addr), 32'h8000);
    check("top_ovf_abs", 32'(overflow), 32'd1);

    // Ten-cycle acknowledge stall on the second data byte
    stall_index = 1;
    stall_len   = 10;
    payload = '{8'h5A, 8'hC3, 8'h96};
    run_prg("stall", 16'h1230, 0, 1'b0);
    stall_index = -1;

    // Foreign index: no activity at all
    clear_log();
    start_dl(8'h00);
    for (int i = 0; i < 5; i++) send_byte(25'(i), 8'(8'h10 + i), 1'b0);
    ioctl_download = 1'b0;
    repeat (10) tick();
    check("foreign_req", 32'(req_seen), 32'd0);
    check("foreign_wait", 32'(wait_seen), 32'd0);
    check("foreign_done", 32'(done_cnt), 32'd0);
    check("foreign_busy", 32'(busy_seen), 32'd0);

    // Window closes after one header byte
    clear_log();
    start_dl(PRG_IDX);
    send_byte(25'd0, 8'h00, 1'b0);
    ioctl_download = 1'b0;
    repeat (5) tick();
    check("short_busy", 32'(busy), 32'd0);
    check("short_req", 32'(req_seen), 32'd0);
    check("short_done", 32'(done_cnt), 32'd0);
    check("short_nwr", 32'(wq.size()), 32'd0);

    // Restart just after entering pointer fix-up: no pointer writes, new load
    clear_log();
    ack_delay = 0;
    start_dl(PRG_IDX);
    send_byte(25'd0, 8'h00, 1'b0);
    send_byte(25'd1, 8'h20, 1'b0);
    send_byte(25'd2, 8'h11, 1'b0);
    send_byte(25'd3, 8'h22, 1'b0);
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    send_byte(25'd0, 8'h10, 1'b0);
    send_byte(25'd1, 8'h30, 1'b0);
    send_byte(25'd2, 8'h33, 1'b0);
    ioctl_download = 1'b0;
    wait_idle(3000);
    tick();
    exp_q   = '{24'h200011, 24'h200122, 24'h301033,
                24'h002A11, 24'h002B30, 24'h002C11,
                24'h002D30, 24'h002E11, 24'h002F30};
    exp_ovf = 1'b0;
    exp_end = 16'h3011;
    compare_log("abort");

    // Reset in the middle of pointer fix-up
    clear_log();
    ack_delay   = 0;
    payload     = '{8'h01, 8'h02};
    build_model(16'h0500);
    stall_index = 5;
    stall_len   = 100000;
    start_dl(PRG_IDX);
    send_byte(25'd0, 8'h00, 1'b0);
    send_byte(25'd1, 8'h05, 1'b0);
    send_byte(25'd2, 8'h01, 1'b0);
    send_byte(25'd3, 8'h02, 1'b0);
    ioctl_download = 1'b0;
    n = 0;
    while (wq.size() < 5 && n < 500) begin tick(); n++; end
    check("prst_nwr", 32'(wq.size()), 32'd5);
    n = 0;
    while (!dma_req && n < 50) begin tick(); n++; end
    check("prst_req_pending", 32'(dma_req), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    req_seen = 0;
    check("prst_req", 32'(dma_req), 32'd0);
    check("prst_busy", 32'(busy), 32'd0);
    check("prst_wait", 32'(ioctl_wait), 32'd0);
    for (int i = 0; i < 5 && i < wq.size(); i++)
      check($sformatf("prst_wr%0d", i), 32'(wq[i]), 32'(exp_q[i]));
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check("prst_after_nwr", 32'(wq.size()), 32'd5);
    check("prst_after_req", 32'(req_seen), 32'd0);
    check("prst_after_busy", 32'(busy), 32'd0);
    stall_index = -1;

    // Randomized loads, including ones near and above the top of RAM
    for (int it = 0; it < 6; it++) begin
      case ($urandom_range(0, 2))
        0:       load = 16'($urandom_range(0, 32'h7000));
        1:       load = 16'(32'h8000 - $urandom_range(1, 6));
        default: load = 16'($urandom_range(32'h8000, 32'hFFFF));
      endcase
      payload.delete();
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) payload.push_back(8'($urandom));
      run_prg($sformatf("rnd%0d", it), load, $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
